// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one variable-latency memory port between instruction fetch and MEM-stage data access
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              FlushF,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              StallF,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  input  logic [2:0]        dm_mode,
  output logic              dm_valid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              StallM,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [2:0]        mem_mode,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;
  localparam logic [3:0] SL = 4'(STARVE_LIMIT);
  state_t state;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [2:0] mode_q;
  logic we_q, discard, busy, if_elig, dm_elig, grant_dm;
  logic [3:0] streak;
  assign if_elig = if_req & ~if_valid;
  assign dm_elig = dm_req & ~dm_valid;
  assign grant_dm = dm_elig & ~(if_elig & (streak == SL));
  assign busy = state != IDLE;
  assign mem_req = busy;
  assign mem_we = busy & we_q;
  assign mem_addr = busy ? addr_q : '0;
  assign mem_wdata = busy ? wdata_q : '0;
  assign mem_mode = busy ? mode_q : '0;
  assign StallF = if_req & ~if_valid;
  assign StallM = dm_req & ~dm_valid;
  // fetches are always word reads, so the fetch grant loads fixed we/wdata/mode values
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      mode_q <= '0;
      we_q <= 1'b0;
      discard <= 1'b0;
      streak <= '0;
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      if_rdata <= '0;
      dm_rdata <= '0;
    end else begin
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      if (state == IDLE) begin
        if (grant_dm) begin
          state <= BUSY_DM;
          addr_q <= dm_addr;
          we_q <= dm_we;
          wdata_q <= dm_wdata;
          mode_q <= dm_mode;
          streak <= if_req ? streak + {3'b000, streak != SL} : '0;
        end else if (if_elig) begin
          state <= BUSY_IF;
          addr_q <= if_addr;
          we_q <= 1'b0;
          wdata_q <= '0;
          mode_q <= 3'b010;
          streak <= '0;
        end
      end else begin
        if (state == BUSY_IF && FlushF) discard <= 1'b1;
        if (mem_ready) begin
          state <= IDLE;
          discard <= 1'b0;
          if (state == BUSY_IF && !(discard || FlushF)) begin
            if_valid <= 1'b1;
            if_rdata <= mem_rdata;
          end
          if (state == BUSY_DM) begin
            dm_valid <= 1'b1;
            if (!we_q) dm_rdata <= mem_rdata;
          end
        end
      end
    end
  end
endmodule
